// File: rtl/cp0_exc_seq.sv
//==============================================================================
// Module   : cp0_exc_seq
// Purpose  : Exception/interrupt sequencer owning the CP0 register port.
//            Passes CPU MTC0/MFC0 through while idle; on interrupt entry it
//            saves EPC and Cause, sets Status.EXL and redirects the PC; on
//            ERET it clears Status.EXL and redirects to EPC.
// Options  : CP0_VECTORED_IRQ_EN - per-line vector offsets (index << 5).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_exc_seq #(
    parameter int          IRQ_N        = 6,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [IRQ_N-1:0] irq_req,
    input  logic             eret,
    input  logic [31:0]      epc_in,
    input  logic [4:0]       cpu_r_in,
    input  logic [4:0]       cpu_w_in,
    input  logic [2:0]       cpu_sel,
    input  logic [31:0]      cpu_din,
    input  logic             cpu_we,
    output logic [31:0]      cpu_rdata,
    output logic [4:0]       cp0_r_in,
    output logic [4:0]       cp0_w_in,
    output logic [2:0]       cp0_sel,
    output logic [31:0]      cp0_din,
    output logic             cp0_we,
    input  logic [31:0]      cp0_rdata,
    output logic             busy,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic [IRQ_N-1:0] irq_ack
);

    localparam logic [4:0] c_REG_STATUS = 5'd12;
    localparam logic [4:0] c_REG_CAUSE  = 5'd13;
    localparam logic [4:0] c_REG_EPC    = 5'd14;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_EPC   = 3'd1;
    localparam logic [2:0] S_W_CAUSE = 3'd2;
    localparam logic [2:0] S_W_STAT  = 3'd3;
    localparam logic [2:0] S_REDIR   = 3'd4;
    localparam logic [2:0] S_E_STAT  = 3'd5;
    localparam logic [2:0] S_E_REDIR = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_ie;
    logic             r_exl;
    logic [IRQ_N-1:0] r_irq_id;
    logic [31:0]      r_epc;

    logic [IRQ_N-1:0] w_req_onehot;
    logic             w_accept_irq;
    logic             w_cpu_stat_wr;
    logic [7:0]       w_ip;
    logic [31:0]      w_vector;

    // Isolate the lowest set request bit (bit 0 has highest priority).
    assign w_req_onehot  = irq_req & (~irq_req + IRQ_N'(1));
    // Acceptance looks only at the shadows as they stood before this edge.
    assign w_accept_irq  = (|irq_req) && r_ie && !r_exl;
    assign w_cpu_stat_wr = cpu_we && (cpu_w_in == c_REG_STATUS) && (cpu_sel == 3'd0);

    // Cause.IP field: accepted line zero-extended to eight bits.
    always_comb begin
        w_ip               = '0;
        w_ip[IRQ_N-1:0]    = r_irq_id;
    end

`ifdef CP0_VECTORED_IRQ_EN
    logic [2:0] w_idx;

    // Binary position of the accepted line selects a 32-byte vector slot.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (r_irq_id[i]) w_idx = 3'(i);
        end
    end

    assign w_vector = HANDLER_BASE + {24'b0, w_idx, 5'b0};
`else
    assign w_vector = HANDLER_BASE;
`endif

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: ERET wins over interrupts; sequences run straight through.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (eret)              w_next = S_E_STAT;
                else if (w_accept_irq) w_next = S_W_EPC;
                else                   w_next = S_IDLE;
            end
            S_W_EPC:   w_next = S_W_CAUSE;
            S_W_CAUSE: w_next = S_W_STAT;
            S_W_STAT:  w_next = S_REDIR;
            S_REDIR:   w_next = S_IDLE;
            S_E_STAT:  w_next = S_E_REDIR;
            S_E_REDIR: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Shadow IE/EXL track every Status write; capture line and EPC on accept.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ie     <= 1'b0;
            r_exl    <= 1'b0;
            r_irq_id <= '0;
            r_epc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_stat_wr) begin
                        r_ie  <= cpu_din[0];
                        r_exl <= cpu_din[1];
                    end
                    if (!eret && w_accept_irq) begin
                        r_irq_id <= w_req_onehot;
                        r_epc    <= epc_in;
                    end
                end
                S_W_STAT: begin
                    r_ie  <= cp0_rdata[0];
                    r_exl <= 1'b1;
                end
                S_E_STAT: begin
                    r_ie  <= cp0_rdata[0];
                    r_exl <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Port ownership: CPU in IDLE, one sequencer access per state otherwise.
    always_comb begin
        cp0_r_in    = 5'd0;
        cp0_w_in    = 5'd0;
        cp0_sel     = 3'd0;
        cp0_din     = 32'd0;
        cp0_we      = 1'b0;
        cpu_rdata   = 32'd0;
        busy        = (r_state != S_IDLE);
        redir_valid = 1'b0;
        redir_pc    = 32'd0;
        irq_ack     = '0;
        case (r_state)
            S_IDLE: begin
                cp0_r_in  = cpu_r_in;
                cp0_w_in  = cpu_w_in;
                cp0_sel   = cpu_sel;
                cp0_din   = cpu_din;
                cp0_we    = cpu_we;
                cpu_rdata = cp0_rdata;
            end
            S_W_EPC: begin
                cp0_w_in = c_REG_EPC;
                cp0_din  = r_epc;
                cp0_we   = 1'b1;
            end
            S_W_CAUSE: begin
                cp0_w_in = c_REG_CAUSE;
                cp0_din  = {16'b0, w_ip, 8'b0};
                cp0_we   = 1'b1;
            end
            S_W_STAT: begin
                cp0_r_in = c_REG_STATUS;
                cp0_w_in = c_REG_STATUS;
                cp0_din  = cp0_rdata | 32'h0000_0002;
                cp0_we   = 1'b1;
            end
            S_REDIR: begin
                redir_valid = 1'b1;
                redir_pc    = w_vector;
                irq_ack     = r_irq_id;
            end
            S_E_STAT: begin
                cp0_r_in = c_REG_STATUS;
                cp0_w_in = c_REG_STATUS;
                cp0_din  = cp0_rdata & ~32'h0000_0002;
                cp0_we   = 1'b1;
            end
            S_E_REDIR: begin
                cp0_r_in    = c_REG_EPC;
                redir_valid = 1'b1;
                redir_pc    = cp0_rdata;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/cp0_exc_seq.md
# cp0_exc_seq

Exception/interrupt sequencer sitting between the CPU datapath and the CP0 register store. It owns the CP0 read/write port: CPU MTC0/MFC0 pass through while idle. On an accepted interrupt or ERET it takes the port and issues its own single-register writes and reads, one per cycle, to save EPC/Cause, set or clear Status.EXL, and redirect the PC. It stalls the CPU for the duration of each sequence.

## Interface
- `IRQ_N`, 6: interrupt request lines, 1..8.
- `HANDLER_BASE`, 32'h0000_4180: handler entry address.
- `clk`  in  1  clock; all state changes on rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `irq_req`  in  IRQ_N  level interrupt requests; bit 0 is highest priority.
- `eret`  in  1  one-cycle ERET request from decode.
- `epc_in`  in  32  PC to save, sampled in the acceptance cycle.
- `cpu_r_in`, `cpu_w_in`  in  5  CPU CP0 read/write register numbers.
- `cpu_sel`  in  3  CPU sel field.
- `cpu_din`  in  32  CPU MTC0 data.
- `cpu_we`  in  1  CPU MTC0 write enable.
- `cpu_rdata`  out  32  MFC0 read data to CPU.
- `cp0_r_in`, `cp0_w_in`  out  5  to CP0 store.
- `cp0_sel`  out  3  to CP0 store.
- `cp0_din`  out  32  to CP0 store.
- `cp0_we`  out  1  to CP0 store.
- `cp0_rdata`  in  32  combinational read data from CP0 store.
- `busy`  out  1  CPU stall; high in every non-IDLE state.
- `redir_valid`  out  1  one-cycle PC redirect strobe.
- `redir_pc`  out  32  redirect target.
- `irq_ack`  out  IRQ_N  one-hot acknowledge, pulsed with `redir_valid` on interrupt entry.

## Operation
- Registers: Status = reg 12, Cause = reg 13, EPC = reg 14, all sel 0. Status bit 0 = IE, bit 1 = EXL.
- Shadow flags `ie`, `exl`, reset 0:
  - A CPU write to reg 12 sel 0 in IDLE updates them from `cpu_din[1:0]`.
  - The sequencer's own Status writes also update them.
- IDLE:
  - All `cpu_*` signals pass straight to `cp0_*`; `cpu_rdata = cp0_rdata`.
  - `eret` takes priority: go to E_STAT.
  - Otherwise, when `|irq_req && ie && !exl`: latch the lowest-index set request as one-hot `irq_id`, latch `epc_in`, and go to W_EPC.
  - Acceptance uses the pre-edge shadows. A same-cycle CPU write still completes.
- Non-IDLE: CPU inputs are ignored and `cpu_rdata = 0`.
- Interrupt entry:
  - W_EPC: write reg 14 = latched EPC.
  - W_CAUSE: write reg 13 = `{16'b0, IP[7:0], 8'b0}`. IP holds the zero-extended `irq_id`; ExcCode is 0.
  - W_STAT: `cp0_r_in = 12`; write reg 12 = `cp0_rdata | 2`; set `exl`.
  - REDIR: `redir_valid = 1`, `redir_pc` = vector, `irq_ack = irq_id`, no CP0 write. Then return to IDLE.
- ERET:
  - E_STAT: read reg 12; write `cp0_rdata & ~2`; clear `exl`.
  - E_REDIR: `cp0_r_in = 14`; `redir_valid = 1`, `redir_pc = cp0_rdata`. Then return to IDLE.
- ERET while `exl = 0` is still executed; the EXL clear is a no-op.
- `eret` and `irq_req` arriving while busy are ignored. Requests are level signals and are re-evaluated on return to IDLE.

## Timing
- Interrupt accepted in cycle T: CP0 writes at the edges ending T+1, T+2, T+3. Redirect is in T+4; `busy` is high T+1..T+4.
- ERET in cycle T: Status write at the edge ending T+1; redirect in T+2; `busy` is high T+1..T+2.
- A new sequence can be accepted in the first IDLE cycle after a redirect.
- `cp0_we` is combinational from state; it never asserts in REDIR or E_REDIR.
- Reset values, asynchronously forced while `clr_n` is low:
  - State goes to IDLE.
  - `ie`, `exl`, `irq_id` and the EPC latch are 0.
  - `busy`, `redir_valid`, `irq_ack` are 0.
  - `cp0_*` outputs follow the CPU inputs.
- Reset mid-sequence aborts it. CP0 writes already made are not undone.

## Configuration
- `CP0_VECTORED_IRQ_EN` defined: interrupt vector = `HANDLER_BASE + (index(irq_id) << 5)`, where index is the binary position of the accepted line.
- Undefined: every interrupt vectors to `HANDLER_BASE`.
- ERET behaviour is identical either way.

## Test plan
- Reset: hold `clr_n` low with `irq_req = 6'h3F` -> `busy = 0`, `redir_valid = 0`, `irq_ack = 0`. After release with `ie = 0`, no acceptance.
- CPU writes Status = 1, then `irq_req = 6'b000110` with `epc_in = 32'h0040_0010`:
  - Writes seen in order: reg 14 = 32'h0040_0010, reg 13 = 32'h0000_0200, reg 12 = 32'h0000_0003.
  - Redirect in T+4 to 32'h0000_41A0 (vectored) or 32'h0000_4180 (non-vectored); `irq_ack = 6'b000010`.
- Second interrupt while `exl = 1` -> not accepted. Then ERET with EPC = 32'h0040_0010 -> reg 12 written 32'h0000_0001; redirect to 32'h0040_0010 in T+2.
- `eret` and `irq_req` asserted in the same IDLE cycle with `ie = 1` -> ERET path runs. The interrupt is accepted in the IDLE cycle after the ERET redirect.
- `clr_n` pulsed low in W_CAUSE -> immediate IDLE, no REDIR, `exl` shadow 0.
- In IDLE, MTC0 reg 9 sel 2 = 32'hDEAD_BEEF -> passes through to `cp0_*` unchanged; `cpu_rdata` mirrors `cp0_rdata`.
